// File: rtl/mux_4x1_2x1_if.sv
// mux_4x1_2x1_if
// Bundles the data, select, enable and registered-output signals of the
// registered 4:1 selector so producer and selector connect through one port.
//   i0..i3  : WIDTH-bit data candidates
//   s0, s1  : select bits, s0 is the MSB ({s0,s1} picks i0..i3)
//   en      : capture enable for the output register
//   y       : registered selected data (WIDTH bits)
//   y_valid : high once y holds data captured since the last reset
// Modports: master drives data/select/enable and observes y; slave is the
// selector itself.
interface mux_4x1_2x1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic             s0;
  logic             s1;
  logic             en;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  modport master (
    output i0, i1, i2, i3, s0, s1, en,
    input  y, y_valid
  );

  modport slave (
    input  i0, i1, i2, i3, s0, s1, en,
    output y, y_valid
  );
endinterface

// File: rtl/mux_4x1_2x1.sv
// mux_2x1
// Plain WIDTH-bit 2:1 selector: out = sel ? b : a. Purely combinational.
//   a, b : data candidates
//   sel  : chooses b when high, a when low
//   out  : selected data
module mux_2x1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);
  assign out = sel ? b : a;
endmodule

// mux_4x1_2x1
// Registered 4:1 data selector built from three 2:1 stages. The first two
// stages pick within the pairs {i0,i1} and {i2,i3} using s1; the final stage
// picks between the pairs using s0. The result is captured in an output
// register, so y follows the inputs with exactly one clock of latency.
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset, clears y and y_valid
//   bus : slave side of mux_4x1_2x1_if (i0..i3, s0, s1, en in; y, y_valid out)
module mux_4x1_2x1 #(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  mux_4x1_2x1_if.slave  bus
);
  logic [WIDTH-1:0] m01;
  logic [WIDTH-1:0] m23;
  logic [WIDTH-1:0] sel_d;
  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;

  // s1 is the select LSB, so it resolves the choice inside each pair.
  mux_2x1 #(.WIDTH(WIDTH)) u_stage_a (
    .a   (bus.i0),
    .b   (bus.i1),
    .sel (bus.s1),
    .out (m01)
  );

  mux_2x1 #(.WIDTH(WIDTH)) u_stage_b (
    .a   (bus.i2),
    .b   (bus.i3),
    .sel (bus.s1),
    .out (m23)
  );

  // s0 is the select MSB, so it chooses between the two pair results.
  mux_2x1 #(.WIDTH(WIDTH)) u_stage_c (
    .a   (m01),
    .b   (m23),
    .sel (bus.s0),
    .out (sel_d)
  );

  // Output register: reset wins over enable; with en low the previous
  // capture (and its valid flag) is held indefinitely.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (bus.en) begin
      y_q       <= sel_d;
      y_valid_q <= 1'b1;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
endmodule

// File: tb/tb_mux_4x1_2x1.sv
// tb_mux_4x1_2x1
// Directed bench for the registered 4:1 selector. Two instances share clk and
// rst: a 1-bit build for select/isolation/enable scenarios and an 8-bit build
// for wide-data and mid-stream reset scenarios. Inputs change 1 time unit
// after a rising edge and y is checked 1 time unit after the following edge.
module tb_mux_4x1_2x1;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mux_4x1_2x1_if #(.WIDTH(1)) bus1 ();
  mux_4x1_2x1_if #(.WIDTH(8)) bus8 ();

  mux_4x1_2x1 #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mux_4x1_2x1 #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the 1-bit instance's data, select and enable.
  task automatic drive1(input logic a0, input logic a1, input logic a2,
                        input logic a3, input logic s0, input logic s1,
                        input logic en);
    bus1.i0 = a0;
    bus1.i1 = a1;
    bus1.i2 = a2;
    bus1.i3 = a3;
    bus1.s0 = s0;
    bus1.s1 = s1;
    bus1.en = en;
  endtask

  // Advances one rising edge and settles before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    bus8.i0 = 8'hFF; bus8.i1 = 8'hFF; bus8.i2 = 8'hFF; bus8.i3 = 8'hFF;
    bus8.s0 = 1'b1;  bus8.s1 = 1'b1;  bus8.en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus1.y !== 1'b0 || bus1.y_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold%0d: y=%b y_valid=%b, required y=0 y_valid=0",
                 c, bus1.y, bus1.y_valid);
      end
    end
    checks++;
    if (bus8.y !== 8'h00 || bus8.y_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_wide: y=%h y_valid=%b, required y=00 y_valid=0",
               bus8.y, bus8.y_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus1.y !== 1'b1 || bus1.y_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release: y=%b y_valid=%b, required y=1 y_valid=1",
               bus1.y, bus1.y_valid);
    end
  endtask

  task automatic test_one_hot_select();
    logic [3:0] onehot;
    logic [1:0] sel;
    for (int k = 0; k < 4; k++) begin
      onehot = 4'b0001 << k;
      sel    = 2'(k);
      drive1(onehot[0], onehot[1], onehot[2], onehot[3], sel[1], sel[0], 1'b1);
      tick();
      checks++;
      if (bus1.y !== 1'b1 || bus1.y_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL one_hot_i%0d: y=%b y_valid=%b, required y=1 y_valid=1",
                 k, bus1.y, bus1.y_valid);
      end
    end
    // Latency: a new selection must not show before the next edge.
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    checks++;
    if (bus1.y !== 1'b1) begin
      failures++;
      $display("[TB] FAIL latency_no_comb: y=%b, required y=1", bus1.y);
    end
    tick();
    checks++;
    if (bus1.y !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_one_cycle: y=%b, required y=0", bus1.y);
    end
  endtask

  task automatic test_isolation();
    drive1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus1.y !== 1'b1) begin
      failures++;
      $display("[TB] FAIL isolation_sel10: y=%b, required y=1", bus1.y);
    end
    bus1.s1 = 1'b1;
    tick();
    checks++;
    if (bus1.y !== 1'b0) begin
      failures++;
      $display("[TB] FAIL isolation_sel11: y=%b, required y=0", bus1.y);
    end
    drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus1.y !== 1'b1) begin
      failures++;
      $display("[TB] FAIL isolation_all_ones: y=%b, required y=1", bus1.y);
    end
  endtask

  task automatic test_enable_hold();
    drive1(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus1.y !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_capture: y=%b, required y=1", bus1.y);
    end
    drive1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus1.y !== 1'b1 || bus1.y_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL hold_cycle%0d: y=%b y_valid=%b, required y=1 y_valid=1",
                 c, bus1.y, bus1.y_valid);
      end
    end
    bus1.en = 1'b1;
    tick();
    checks++;
    if (bus1.y !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_release: y=%b, required y=0", bus1.y);
    end
  endtask

  task automatic test_wide_data();
    logic [7:0] expected [4];
    logic [1:0] sel;
    expected[0] = 8'h11; expected[1] = 8'h22;
    expected[2] = 8'h44; expected[3] = 8'h88;
    bus8.i0 = 8'h11; bus8.i1 = 8'h22; bus8.i2 = 8'h44; bus8.i3 = 8'h88;
    bus8.en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel     = 2'(k);
      bus8.s0 = sel[1];
      bus8.s1 = sel[0];
      tick();
      checks++;
      if (bus8.y !== expected[k]) begin
        failures++;
        $display("[TB] FAIL wide_sel%0d: y=%h, required y=%h",
                 k, bus8.y, expected[k]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    rst     = 1'b1;
    bus8.en = 1'b1;
    tick();
    checks++;
    if (bus8.y !== 8'h00 || bus8.y_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_clear: y=%h y_valid=%b, required y=00 y_valid=0",
               bus8.y, bus8.y_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus8.y !== 8'h88 || bus8.y_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_recover: y=%h y_valid=%b, required y=88 y_valid=1",
               bus8.y, bus8.y_valid);
    end
  endtask

  // Reset must beat a deasserted enable too.
  task automatic test_reset_over_hold();
    bus8.en = 1'b0;
    rst     = 1'b1;
    tick();
    checks++;
    if (bus8.y !== 8'h00 || bus8.y_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_en_low: y=%h y_valid=%b, required y=00 y_valid=0",
               bus8.y, bus8.y_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus8.y !== 8'h00 || bus8.y_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_then_hold: y=%h y_valid=%b, required y=00 y_valid=0",
               bus8.y, bus8.y_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus8.i0 = '0; bus8.i1 = '0; bus8.i2 = '0; bus8.i3 = '0;
    bus8.s0 = 1'b0; bus8.s1 = 1'b0; bus8.en = 1'b0;
    #1;
    $display("[TB] starting directed tests");
    test_reset();
    test_one_hot_select();
    test_isolation();
    test_enable_hold();
    test_wide_data();
    test_reset_mid_stream();
    test_reset_over_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
